// File: rtl/lfsr_seq_ctrl.sv
// Control FSM for a 3-stage seeded shift register: clears, serially seeds, then clocks it to build
// WORD_W-bit words delivered over valid/ready. Optional warm-up phase: `define LFSR_SEQ_WARMUP_EN.
module lfsr_seq_ctrl #(
  parameter int WIDTH  = 3,
  parameter int WORD_W = 8,
  parameter int WARMUP = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  seed_value,
  input  logic              seed_start,
  output logic              seed_err,
  output logic              seeded,
  output logic              busy,
  output logic              lfsr_rst,
  output logic              lfsr_ena,
  output logic              lfsr_seed,
  input  logic              lfsr_out,
  input  logic              req_valid,
  output logic              req_ready,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data
);

  localparam int CNT_MAX = (WIDTH > WORD_W) ? ((WIDTH > WARMUP) ? WIDTH : WARMUP)
                                            : ((WORD_W > WARMUP) ? WORD_W : WARMUP);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GEN_LAST  = CNT_W'(WORD_W - 1);
`ifdef LFSR_SEQ_WARMUP_EN
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(WARMUP - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    READY,
    GEN,
`ifdef LFSR_SEQ_WARMUP_EN
    WARM,
`endif
    HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    seed_q, seed_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                seeded_q, seeded_d;
  logic                err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      seed_q   <= '0;
      word_q   <= '0;
      seeded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      seed_q   <= seed_d;
      word_q   <= word_d;
      seeded_q <= seeded_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    seed_d     = seed_q;
    word_d     = word_q;
    seeded_d   = seeded_q;
    err_d      = err_q;
    lfsr_rst   = 1'b0;
    lfsr_ena   = 1'b0;
    lfsr_seed  = 1'b0;
    req_ready  = 1'b0;
    word_valid = 1'b0;
    busy       = 1'b0;

    case (state_q)
      IDLE: begin
        lfsr_rst = 1'b1;
        if (seed_start) begin
          seeded_d = 1'b0;
          if (seed_value == '0) begin
            err_d = 1'b1;
          end else begin
            err_d   = 1'b0;
            seed_d  = seed_value;
            state_d = CLEAR;
          end
        end
      end
      CLEAR: begin
        lfsr_rst = 1'b1;
        busy     = 1'b1;
        cnt_d    = '0;
        state_d  = LOAD;
      end
      LOAD: begin
        // Seed goes in LSB first; the latch shifts right so bit 0 is always the next one.
        busy      = 1'b1;
        lfsr_seed = seed_q[0];
        seed_d    = seed_q >> 1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LOAD_LAST) begin
          cnt_d = '0;
`ifdef LFSR_SEQ_WARMUP_EN
          state_d = WARM;
`else
          seeded_d = 1'b1;
          state_d  = READY;
`endif
        end
      end
`ifdef LFSR_SEQ_WARMUP_EN
      WARM: begin
        busy     = 1'b1;
        lfsr_ena = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == WARM_LAST) begin
          cnt_d    = '0;
          seeded_d = 1'b1;
          state_d  = READY;
        end
      end
`endif
      READY: begin
        // Recirculate the tap so an idle register is not overwritten with a stray seed bit.
        req_ready = 1'b1;
        lfsr_seed = lfsr_out;
        if (seed_start) begin
          seeded_d = 1'b0;
          if (seed_value == '0) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            err_d   = 1'b0;
            seed_d  = seed_value;
            state_d = CLEAR;
          end
        end else if (req_valid) begin
          cnt_d   = '0;
          state_d = GEN;
        end
      end
      GEN: begin
        busy     = 1'b1;
        lfsr_ena = 1'b1;
        word_d   = {word_q[WORD_W-2:0], lfsr_out};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == GEN_LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end
      end
      HOLD: begin
        busy       = 1'b1;
        lfsr_seed  = lfsr_out;
        word_valid = 1'b1;
        if (word_ready) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
  end

  assign seeded    = seeded_q;
  assign seed_err  = err_q;
  assign word_data = word_q;

endmodule
